// File: rtl/dbg_frame_master.sv
// rtl/dbg_frame_master.sv - serial frame to debug-port transaction bridge
// Collects a 9-byte request, runs one debug transaction, returns a 5-byte response.
module dbg_frame_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        sys_clk_i,
  input  logic        rstn_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_RX, S_BUS, S_TX} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  state_t        state;
  logic [3:0]    cnt;
  logic [TW-1:0] tcnt;
  logic [31:0]   rdata;
  logic [7:0]    frame_q [0:7];
  logic          rx_fire;
  logic          tx_fire;

  assign rx_fire = rx_valid_i & rx_ready_o;
  assign tx_fire = tx_valid_o & tx_ready_i;
  assign busy_o  = (state != S_RX) || (cnt != 4'd0);

  // Bytes 0..7 are buffered; byte 8 is consumed straight from the bus.
  always_ff @(posedge sys_clk_i) begin
    if (rx_fire && (cnt < 4'd8)) begin
      frame_q[cnt[2:0]] <= rx_data_i;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= S_RX;
      cnt        <= 4'd0;
      tcnt       <= '0;
      rdata      <= 32'd0;
      rx_ready_o <= 1'b1;
      tx_valid_o <= 1'b0;
      tx_data_o  <= 8'd0;
      dbg_cmd_o  <= 8'd0;
      dbg_addr_o <= 32'd0;
      dbg_data_o <= 32'd0;
    end else begin
      case (state)
        S_RX: begin
          if (rx_fire) begin
            if (cnt == 4'd8) begin
              cnt        <= 4'd0;
              tcnt       <= '0;
              rx_ready_o <= 1'b0;
              dbg_addr_o <= {frame_q[4], frame_q[3], frame_q[2], frame_q[1]};
              dbg_data_o <= {rx_data_i, frame_q[7], frame_q[6], frame_q[5]};
              if (frame_q[0] == 8'd0) begin
                state      <= S_TX;
                rdata      <= 32'd0;
                tx_data_o  <= 8'h00;
                tx_valid_o <= 1'b1;
              end else begin
                state     <= S_BUS;
                dbg_cmd_o <= frame_q[0];
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end

        S_BUS: begin
          // Ready takes priority over a timeout landing in the same cycle.
          if (dbg_ready_i) begin
            state      <= S_TX;
            dbg_cmd_o  <= 8'd0;
            rdata      <= dbg_data_i;
            tx_data_o  <= 8'h00;
            tx_valid_o <= 1'b1;
          end else if (TO_EN && (tcnt == TLAST)) begin
            state      <= S_TX;
            dbg_cmd_o  <= 8'd0;
            rdata      <= 32'd0;
            tx_data_o  <= 8'h01;
            tx_valid_o <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_TX: begin
          if (tx_fire) begin
            if (cnt == 4'd4) begin
              state      <= S_RX;
              cnt        <= 4'd0;
              tx_valid_o <= 1'b0;
              tx_data_o  <= 8'd0;
              rx_ready_o <= 1'b1;
            end else begin
              cnt       <= cnt + 4'd1;
              tx_data_o <= rdata[8*cnt[1:0] +: 8];
            end
          end
        end

        default: begin
          state <= S_RX;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_frame_master.sv
// tb/tb_dbg_frame_master.sv - randomized frame traffic against a timeline model
// The model predicts outputs from the cycle the 9th byte lands and the planned core latency.
module tb_dbg_frame_master;

  localparam int T     = 16;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  dbg_cmd;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata = 32'd0;
  logic        dbg_ready = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  dbg_frame_master #(.TIMEOUT_CYCLES(T)) dut (
    .sys_clk_i  (clk),
    .rstn_i     (rstn),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .dbg_cmd_o  (dbg_cmd),
    .dbg_addr_o (dbg_addr),
    .dbg_data_o (dbg_wdata),
    .dbg_data_i (dbg_rdata),
    .dbg_ready_i(dbg_ready),
    .busy_o     (busy)
  );

  int compared = 0;
  int mismatched = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endfunction

  // Planned core behaviour per frame, consumed when the frame's 9th byte lands.
  int          plan_d_q[$];
  logic [31:0] plan_r_q[$];
  int          cur_d = NEVER;
  logic [31:0] cur_r = 32'd0;

  int          cyc = 0;
  int          rxn = 0;
  logic [7:0]  fb [0:8];
  bit          in_txn = 1'b0;
  int          n9 = 0;
  int          lat = 0;
  logic [7:0]  ecmd = 8'd0;
  logic [31:0] eaddr = 32'd0;
  logic [31:0] edata = 32'd0;
  logic [7:0]  resp [0:4];
  logic [7:0]  got [0:4];
  logic [7:0]  last_resp [0:4];
  int          tx_idx = 0;
  int          cmd_hi = 0;
  int          first_valid = -1;
  int          last_cmd_hi = 0;
  int          last_lat = 0;
  int          done_cnt = 0;
  int          tx_mode = 0;
  bit          gaps = 1'b0;

  always @(negedge clk) begin : mon
    logic [7:0]  exp_cmd;
    bit          exp_tv;
    int          d;
    logic [31:0] r;
    logic [7:0]  st;
    cyc++;
    if (!rstn) begin
      chk("rst_rx_ready", rx_ready, 1);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_cmd", dbg_cmd, 0);
      chk("rst_addr", dbg_addr, 0);
      chk("rst_wdata", dbg_wdata, 0);
      chk("rst_busy", busy, 0);
      rxn = 0;
      in_txn = 1'b0;
      eaddr = 32'd0;
      edata = 32'd0;
    end else begin
      exp_cmd = (in_txn && cyc <= n9 + lat) ? ecmd : 8'd0;
      exp_tv  = in_txn && (cyc >= n9 + 1 + lat);
      chk("dbg_cmd", dbg_cmd, exp_cmd);
      chk("dbg_addr", dbg_addr, eaddr);
      chk("dbg_wdata", dbg_wdata, edata);
      chk("rx_ready", rx_ready, !in_txn);
      chk("busy", busy, in_txn || rxn != 0);
      chk("tx_valid", tx_valid, exp_tv);
      if (exp_tv) chk("tx_data", tx_data, resp[tx_idx]);
      if (in_txn && dbg_cmd != 8'd0) cmd_hi++;
      if (exp_tv && first_valid < 0) first_valid = cyc - n9;

      if (rx_valid && rx_ready) begin
        fb[rxn] = rx_data;
        rxn++;
        if (rxn == 9) begin
          rxn = 0;
          in_txn = 1'b1;
          n9 = cyc;
          ecmd = fb[0];
          eaddr = {fb[4], fb[3], fb[2], fb[1]};
          edata = {fb[8], fb[7], fb[6], fb[5]};
          d = NEVER;
          r = 32'd0;
          if (plan_d_q.size() > 0) begin
            d = plan_d_q.pop_front();
            r = plan_r_q.pop_front();
          end
          cur_d = d;
          cur_r = r;
          if (ecmd == 8'd0) begin
            lat = 0;
            st = 8'h00;
            r = 32'd0;
          end else begin
            lat = (d + 1 < T) ? d + 1 : T;
            st = (d < T) ? 8'h00 : 8'h01;
            if (d >= T) r = 32'd0;
          end
          resp[0] = st;
          for (int i = 0; i < 4; i++) resp[i+1] = r[8*i +: 8];
          tx_idx = 0;
          cmd_hi = 0;
          first_valid = -1;
        end
      end

      if (tx_valid && tx_ready && in_txn && tx_idx < 5) begin
        got[tx_idx] = tx_data;
        tx_idx++;
        if (tx_idx == 5) begin
          in_txn = 1'b0;
          for (int i = 0; i < 5; i++) last_resp[i] = got[i];
          last_cmd_hi = cmd_hi;
          last_lat = first_valid;
          done_cnt++;
        end
      end
    end
  end

  // Core model: completes after cur_d cycles of nonzero command; noise on ready otherwise.
  int k = 0;
  always @(posedge clk) begin
    #1;
    if (dbg_cmd != 8'd0) begin
      dbg_ready = (k == cur_d);
      dbg_rdata = (k == cur_d) ? cur_r : $urandom;
      k++;
    end else begin
      k = 0;
      dbg_ready = ($urandom_range(0, 3) == 0);
      dbg_rdata = $urandom;
    end
  end

  always @(posedge clk) begin
    #1;
    case (tx_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = $urandom_range(0, 1) == 1;
      default: tx_ready = (cyc % 3 == 0);
    endcase
  end

  task automatic send_byte(input logic [7:0] b);
    int g;
    rx_data = b;
    rx_valid = 1'b1;
    g = 0;
    @(negedge clk);
    while (!rx_ready && g < 400) begin
      g++;
      @(negedge clk);
    end
    if (g >= 400) fail_now("rx_accept");
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data = $urandom;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] wd,
                            input int dly, input logic [31:0] rd);
    plan_d_q.push_back(dly);
    plan_r_q.push_back(rd);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) send_byte(wd[8*i +: 8]);
  endtask

  task automatic wait_done(input int n);
    int g;
    g = 0;
    while (done_cnt < n && g < 4000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (done_cnt < n) fail_now("response_done");
  endtask

  task automatic chk_resp(input string nm, input logic [39:0] e);
    for (int i = 0; i < 5; i++) chk(nm, last_resp[i], e[39 - 8*i -: 8]);
  endtask

  int ndone = 0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    send_frame(8'h04, 32'h8000_0010, 32'hDEAD_BEEF, 2, 32'h0);
    ndone++; wait_done(ndone);
    chk_resp("t1_resp", 40'h00_00_00_00_00);
    chk("t1_cmd_cycles", last_cmd_hi, 3);
    chk("t1_addr", dbg_addr, 32'h8000_0010);
    chk("t1_wdata", dbg_wdata, 32'hDEAD_BEEF);

    send_frame(8'h03, 32'h0000_0100, 32'h0, 0, 32'h1234_5678);
    ndone++; wait_done(ndone);
    chk_resp("t2_resp", 40'h00_78_56_34_12);
    chk("t2_cmd_cycles", last_cmd_hi, 1);

    send_frame(8'h05, $urandom, $urandom, NEVER, 32'hFFFF_FFFF);
    ndone++; wait_done(ndone);
    chk_resp("t3_resp", 40'h01_00_00_00_00);
    chk("t3_cmd_cycles", last_cmd_hi, 16);

    send_frame(8'h07, $urandom, $urandom, T - 1, 32'hA5A5_0F0F);
    ndone++; wait_done(ndone);
    chk_resp("ready_at_limit_resp", 40'h00_0F_0F_A5_A5);
    chk("ready_at_limit_cycles", last_cmd_hi, 16);

    send_frame(8'h00, 32'h1111_2222, 32'h3333_4444, 0, 32'hCAFE_F00D);
    ndone++; wait_done(ndone);
    chk_resp("t4_resp", 40'h00_00_00_00_00);
    chk("t4_cmd_cycles", last_cmd_hi, 0);
    chk("t4_latency", last_lat, 1);

    tx_mode = 2;
    send_frame(8'h03, 32'h0000_0100, 32'h0, 1, 32'h1234_5678);
    ndone++; wait_done(ndone);
    chk_resp("t5_resp", 40'h00_78_56_34_12);
    tx_mode = 0;

    for (int i = 0; i < 5; i++) send_byte(8'h60 + 8'(i));
    rstn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rstn = 1'b1;
    send_frame(8'h04, 32'h0000_2000, 32'h0BAD_F00D, 0, 32'h0);
    ndone++; wait_done(ndone);
    chk("t6_addr", dbg_addr, 32'h0000_2000);
    chk("t6_wdata", dbg_wdata, 32'h0BAD_F00D);
    chk_resp("t6_resp", 40'h00_00_00_00_00);

    send_frame(8'h09, $urandom, $urandom, NEVER, 32'h0);
    repeat (5) begin @(posedge clk); #1; end
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int n = 0; n < 40; n++) begin
      int dly;
      logic [7:0] c;
      gaps = ($urandom_range(0, 1) == 1);
      tx_mode = $urandom_range(0, 2);
      c = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      dly = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 20);
      send_frame(c, $urandom, $urandom, dly, $urandom);
      ndone++;
    end
    wait_done(ndone);
    repeat (5) begin @(posedge clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
